// File: rtl/uart_controller.sv
// 8N1 UART receiver plus "set rpm" frame parser for the motor PID block.
// Each parsed channel/value pair becomes a one-cycle strobe carrying a signed setpoint.
module uart_controller #(
   parameter int          DATA_WIDTH = 16,
   parameter int unsigned NUM_CHN    = 4,
   parameter int          CLK_FREQ   = 27_000_000,
   parameter int          BAUD_RATE  = 115200,
   localparam int         CHN_WIDTH  = 3
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         uart_rx,
   output logic                         tr_valid_o,
   output logic [CHN_WIDTH-1:0]         tr_chn_o,
   output logic signed [DATA_WIDTH-1:0] tr_data_o
);

   localparam int BAUD_CLK = CLK_FREQ / BAUD_RATE;
   localparam int HALF_CLK = BAUD_CLK / 2;
   localparam int CNT_W    = $clog2(BAUD_CLK + 1);

   localparam logic [7:0] CMD_SET_RPM = 8'h91;
   localparam logic [7:0] END_FRAME   = 8'hFF;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

   typedef enum logic [1:0] {
      WAIT_CMD,
      WAIT_HI,
      WAIT_LO
   } parse_state_t;

   // 13-bit payload {hi[4:0], lo[7:0]} is two's complement; widen with sign.
   function automatic logic signed [DATA_WIDTH-1:0] sext_13(input logic [12:0] v);
      logic signed [12:0] s;
      s = $signed(v);
      return DATA_WIDTH'(s);
   endfunction

   // ---- stage p0/p1: input synchroniser and falling-edge detect ----
   logic rx_p0;
   logic rx_p1;
   logic rx_prev;
   logic rx_fall;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_p0   <= 1'b1;
         rx_p1   <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_p0   <= uart_rx;
         rx_p1   <= rx_p0;
         rx_prev <= rx_p1;
      end
   end

   assign rx_fall = rx_prev & ~rx_p1;

   // ---- receiver FSM ----
   rx_state_t        rx_state_q;
   rx_state_t        rx_state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [2:0]       bit_idx_q;
   logic [7:0]       shreg;
   logic             cnt_clr;
   logic             shift_en;
   logic             rx_done;
   logic             half_tick;
   logic             baud_tick;

   assign half_tick = (cnt_q == CNT_W'(HALF_CLK - 1));
   assign baud_tick = (cnt_q == CNT_W'(BAUD_CLK - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_state_q <= RX_IDLE;
      end else begin
         rx_state_q <= rx_state_d;
      end
   end

   always_comb begin
      rx_state_d = rx_state_q;
      cnt_clr    = 1'b0;
      shift_en   = 1'b0;
      rx_done    = 1'b0;
      case (rx_state_q)
         RX_IDLE: begin
            cnt_clr = 1'b1;
            if (rx_fall) begin
               rx_state_d = RX_START;
            end
         end
         RX_START: begin
            // Line must still be low at mid start bit, otherwise it was a glitch.
            if (half_tick) begin
               cnt_clr    = 1'b1;
               rx_state_d = rx_p1 ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (baud_tick) begin
               cnt_clr  = 1'b1;
               shift_en = 1'b1;
               if (bit_idx_q == 3'd7) begin
                  rx_state_d = RX_STOP;
               end
            end
         end
         RX_STOP: begin
            // A low stop bit is a framing error: the byte is silently dropped.
            if (baud_tick) begin
               cnt_clr    = 1'b1;
               rx_done    = rx_p1;
               rx_state_d = RX_IDLE;
            end
         end
         default: begin
            rx_state_d = RX_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q     <= '0;
         bit_idx_q <= '0;
      end else begin
         cnt_q <= cnt_clr ? '0 : cnt_q + CNT_W'(1);
         if (rx_state_q != RX_DATA) begin
            bit_idx_q <= '0;
         end else if (shift_en) begin
            bit_idx_q <= bit_idx_q + 3'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (shift_en) begin
         shreg <= {rx_p1, shreg[7:1]};
      end
   end

   // ---- parser FSM ----
   parse_state_t p_state_q;
   parse_state_t p_state_d;
   logic [1:0]   chn_p0;
   logic [4:0]   hi_p0;
   logic         load_hi;
   logic         emit;
   logic         chn_ok;

   assign chn_ok = ({30'd0, chn_p0} < 32'(NUM_CHN));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p_state_q <= WAIT_CMD;
      end else begin
         p_state_q <= p_state_d;
      end
   end

   always_comb begin
      p_state_d = p_state_q;
      load_hi   = 1'b0;
      emit      = 1'b0;
      if (rx_done) begin
         case (p_state_q)
            WAIT_CMD: begin
               if (shreg == CMD_SET_RPM) begin
                  p_state_d = WAIT_HI;
               end
            end
            WAIT_HI: begin
               if (shreg == END_FRAME) begin
                  p_state_d = WAIT_CMD;
               end else if (!shreg[7]) begin
                  load_hi   = 1'b1;
                  p_state_d = WAIT_LO;
               end else if (shreg == CMD_SET_RPM) begin
                  p_state_d = WAIT_HI;
               end else begin
                  p_state_d = WAIT_CMD;
               end
            end
            WAIT_LO: begin
               // Every byte here is payload, 8'hFF included.
               emit      = chn_ok;
               p_state_d = WAIT_HI;
            end
            default: begin
               p_state_d = WAIT_CMD;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (load_hi) begin
         chn_p0 <= shreg[6:5];
         hi_p0  <= shreg[4:0];
      end
   end

   // ---- stage p1: registered setpoint outputs, held between strobes ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tr_valid_o <= 1'b0;
         tr_chn_o   <= '0;
         tr_data_o  <= '0;
      end else begin
         tr_valid_o <= emit;
         if (emit) begin
            tr_chn_o  <= CHN_WIDTH'(chn_p0);
            tr_data_o <= sext_13({hi_p0, shreg});
         end
      end
   end

endmodule

// File: tb/tb_uart_controller.sv
// Bench for uart_controller: serial bytes from a table, expected strobes in a scoreboard queue.
module tb_uart_controller;

   localparam int BAUD = 16;

   logic              clk;
   logic              rst;
   logic              uart_rx;
   logic              tr_valid_o;
   logic [2:0]        tr_chn_o;
   logic signed [15:0] tr_data_o;

   uart_controller #(
      .DATA_WIDTH(16),
      .NUM_CHN   (4),
      .CLK_FREQ  (1_600_000),
      .BAUD_RATE (100_000)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .uart_rx   (uart_rx),
      .tr_valid_o(tr_valid_o),
      .tr_chn_o  (tr_chn_o),
      .tr_data_o (tr_data_o)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   typedef struct {
      logic [7:0]  b;
      logic        stop_ok;
      logic        exp_v;
      logic [2:0]  chn;
      logic [15:0] data;
   } vec_t;

   typedef struct {
      logic [2:0]  chn;
      logic [15:0] data;
   } exp_t;

   vec_t        tbl[$];
   exp_t        sbq[$];
   int          checks   = 0;
   int          failures = 0;
   logic        prev_v   = 1'b0;
   logic [2:0]  last_chn = '0;
   logic [15:0] last_data = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic add(input logic [7:0] b, input logic ok, input logic v,
                      input logic [2:0] chn, input logic [15:0] data);
      vec_t r;
      r.b = b; r.stop_ok = ok; r.exp_v = v; r.chn = chn; r.data = data;
      tbl.push_back(r);
   endtask

   task automatic expect_strobe(input logic [2:0] chn, input logic [15:0] data);
      exp_t e;
      e.chn = chn; e.data = data;
      sbq.push_back(e);
      last_chn  = chn;
      last_data = data;
   endtask

   task automatic bit_out(input logic v);
      uart_rx = v;
      repeat (BAUD) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_ok, input logic rst_mid);
      bit_out(1'b0);
      for (int i = 0; i < 8; i++) bit_out(b[i]);
      if (rst_mid) begin
         uart_rx = 1'b1;
         repeat (BAUD / 4) @(negedge clk);
         rst = 1'b1;
         repeat (3) @(negedge clk);
         rst = 1'b0;
         repeat (BAUD - BAUD / 4 - 3) @(negedge clk);
      end else begin
         bit_out(stop_ok);
      end
      uart_rx = 1'b1;
      repeat (2 * BAUD) @(negedge clk);
   endtask

   task automatic check_settled(input string tag);
      check({tag, "_drain"}, 32'(sbq.size()), 32'd0);
      check({tag, "_chn"}, {29'd0, tr_chn_o}, {29'd0, last_chn});
      check({tag, "_data"}, {16'd0, $unsigned(tr_data_o)}, {16'd0, last_data});
      sbq.delete();
   endtask

   always @(negedge clk) begin
      if (tr_valid_o === 1'b1) begin
         check("strobe_width", {31'd0, prev_v}, 32'd0);
         if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_strobe actual=(%0d,%h) required=none", tr_chn_o, tr_data_o);
         end else begin
            check("strobe_chn", {29'd0, tr_chn_o}, {29'd0, sbq[0].chn});
            check("strobe_data", {16'd0, $unsigned(tr_data_o)}, {16'd0, sbq[0].data});
            void'(sbq.pop_front());
         end
      end
      prev_v <= tr_valid_o;
   end

   initial begin
      uart_rx = 1'b1;
      rst     = 1'b1;
      repeat (5) @(negedge clk);
      check("reset_valid", {31'd0, tr_valid_o}, 32'd0);
      check("reset_chn", {29'd0, tr_chn_o}, 32'd0);
      check("reset_data", {16'd0, $unsigned(tr_data_o)}, 32'd0);
      rst = 1'b0;
      repeat (3 * BAUD) @(negedge clk);

      // four pairs in one frame, trailing FF on an idle parser
      add(8'h91, 1, 0, 0, 0);         add(8'h11, 1, 0, 0, 0);
      add(8'hA8, 1, 1, 3'd0, 16'hF1A8);
      add(8'h29, 1, 0, 0, 0);         add(8'hA9, 1, 1, 3'd1, 16'h09A9);
      add(8'h55, 1, 0, 0, 0);         add(8'h0A, 1, 1, 3'd2, 16'hF50A);
      add(8'h75, 1, 0, 0, 0);         add(8'hFF, 1, 1, 3'd3, 16'hF5FF);
      add(8'hFF, 1, 0, 0, 0);
      // short positive frame
      add(8'h91, 1, 0, 0, 0);         add(8'h01, 1, 0, 0, 0);
      add(8'hA8, 1, 1, 3'd0, 16'h01A8); add(8'hFF, 1, 0, 0, 0);
      // pair without command byte
      add(8'h11, 1, 0, 0, 0);         add(8'hA8, 1, 0, 0, 0);
      add(8'hFF, 1, 0, 0, 0);
      // framing error inside a frame, then a clean frame
      add(8'h91, 1, 0, 0, 0);         add(8'h11, 0, 0, 0, 0);
      add(8'hFF, 1, 0, 0, 0);         add(8'h91, 1, 0, 0, 0);
      add(8'h29, 1, 0, 0, 0);         add(8'hA9, 1, 1, 3'd1, 16'h09A9);
      add(8'hFF, 1, 0, 0, 0);
      // repeated command byte restarts the frame
      add(8'h91, 1, 0, 0, 0);         add(8'h91, 1, 0, 0, 0);
      add(8'h29, 1, 0, 0, 0);         add(8'hA9, 1, 1, 3'd1, 16'h09A9);
      add(8'hFF, 1, 0, 0, 0);

      for (int i = 0; i < tbl.size(); i++) begin
         if (tbl[i].exp_v) expect_strobe(tbl[i].chn, tbl[i].data);
         send_byte(tbl[i].b, tbl[i].stop_ok, 1'b0);
         check_settled($sformatf("vec%0d", i));
      end

      // short low glitch while waiting for the low byte must not become a byte
      send_byte(8'h91, 1'b1, 1'b0);
      send_byte(8'h11, 1'b1, 1'b0);
      uart_rx = 1'b0;
      repeat (BAUD / 4) @(negedge clk);
      uart_rx = 1'b1;
      repeat (2 * BAUD) @(negedge clk);
      check_settled("glitch");
      expect_strobe(3'd0, 16'hF1A8);
      send_byte(8'hA8, 1'b1, 1'b0);
      check_settled("glitch_pair");
      send_byte(8'hFF, 1'b1, 1'b0);

      // reset before the stop bit of the low byte discards everything
      send_byte(8'h91, 1'b1, 1'b0);
      send_byte(8'h11, 1'b1, 1'b0);
      send_byte(8'hA8, 1'b1, 1'b1);
      last_chn  = '0;
      last_data = '0;
      check("rst_mid_valid", {31'd0, tr_valid_o}, 32'd0);
      check_settled("rst_mid");
      send_byte(8'h29, 1'b1, 1'b0);
      send_byte(8'hA9, 1'b1, 1'b0);
      check_settled("post_rst_nocmd");
      send_byte(8'hFF, 1'b1, 1'b0);
      send_byte(8'h91, 1'b1, 1'b0);
      send_byte(8'h01, 1'b1, 1'b0);
      expect_strobe(3'd0, 16'h01A8);
      send_byte(8'hA8, 1'b1, 1'b0);
      check_settled("post_rst_frame");
      send_byte(8'hFF, 1'b1, 1'b0);
      check("final_valid", {31'd0, tr_valid_o}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
